// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic inter-stage pipeline register.
// Optional stall statistics are enabled with the PIPE_STATS_EN macro (see pipe_stage_elastic).
package pipe_pkg;

    localparam int unsigned IR_W_DEF   = 32;
    localparam int unsigned A3_W_DEF   = 5;
    localparam int unsigned DATA_W_DEF = 96;
    localparam int unsigned CTRL_W_DEF = 3;

    // Control bit positions within the ctrl vector
    localparam int unsigned CTRL_REGWRITE = 0;
    localparam int unsigned CTRL_MEMTOREG = 1;
    localparam int unsigned CTRL_LINK     = 2;

    // sll $0,$0,0 -- an all-zero instruction word is the architectural NOP
    localparam logic [31:0] NOP_IR = 32'h0;

    // Source selected when the main slot is loaded
    typedef enum logic {
        SRC_INPUT = 1'b0,
        SRC_SKID  = 1'b1
    } m_src_e;

endpackage

// File: rtl/pipe_stage_elastic_slot.sv
// pipe_slot: one storage entry (valid bit plus IR/A3/data/ctrl fields).
// clear has priority over load; a cleared slot always holds all-zero fields.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int unsigned IR_W   = IR_W_DEF,
    parameter int unsigned A3_W   = A3_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CTRL_W = CTRL_W_DEF
) (
    input  logic              CLK,
    input  logic              clear,
    input  logic              load,
    input  logic [IR_W-1:0]   load_IR,
    input  logic [A3_W-1:0]   load_A3,
    input  logic [DATA_W-1:0] load_data,
    input  logic [CTRL_W-1:0] load_ctrl,
    output logic              valid,
    output logic [IR_W-1:0]   IR,
    output logic [A3_W-1:0]   A3,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    // Slot register: clear zeroes everything, load captures a valid beat, else hold
    always_ff @(posedge CLK) begin
        if (clear) begin
            valid <= 1'b0;
            IR    <= '0;
            A3    <= '0;
            data  <= '0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            IR    <= load_IR;
            A3    <= load_A3;
            data  <= load_data;
            ctrl  <= load_ctrl;
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: valid/ready pipeline register with a skid entry so that
// in_ready is registered-state only. Flush turns held entries into NOP bubbles.
// Optional macro PIPE_STATS_EN adds a saturating stall counter on stall_cnt.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int unsigned IR_W   = IR_W_DEF,
    parameter int unsigned A3_W   = A3_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CTRL_W = CTRL_W_DEF
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IR_W-1:0]   in_IR,
    input  logic [A3_W-1:0]   in_A3,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IR_W-1:0]   IR,
    output logic [A3_W-1:0]   A3,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl,
    output logic              skid_full,
    output logic [31:0]       stall_cnt
);

    logic              m_valid;
    logic              s_valid;
    logic [IR_W-1:0]   s_IR;
    logic [A3_W-1:0]   s_A3;
    logic [DATA_W-1:0] s_data;
    logic [CTRL_W-1:0] s_ctrl;

    logic              accept;
    logic              pop;
    logic              kill;
    logic              m_load;
    logic              m_clear;
    logic              s_load;
    logic              s_clear;
    m_src_e            m_src;
    logic [IR_W-1:0]   m_in_IR;
    logic [A3_W-1:0]   m_in_A3;
    logic [DATA_W-1:0] m_in_data;
    logic [CTRL_W-1:0] m_in_ctrl;

    assign in_ready  = ~s_valid & ~reset;
    assign accept    = in_valid & in_ready;
    assign pop       = m_valid & out_ready;
    assign kill      = reset | flush;
    assign out_valid = m_valid;
    assign skid_full = s_valid;

    // Slot control: S only ever fills behind a valid, stalled M, so S.valid implies M.valid
    always_comb begin
        m_clear = kill | (pop & ~s_valid & ~accept);
        m_load  = (pop & s_valid) | (pop & ~s_valid & accept) | (~pop & ~m_valid & accept);
        s_clear = kill | (pop & s_valid);
        s_load  = ~pop & m_valid & accept;
        m_src   = s_valid ? SRC_SKID : SRC_INPUT;
    end

    // Main slot source mux: drain the skid entry first to preserve order
    always_comb begin
        m_in_IR   = in_IR;
        m_in_A3   = in_A3;
        m_in_data = in_data;
        m_in_ctrl = in_ctrl;
        if (m_src == SRC_SKID) begin
            m_in_IR   = s_IR;
            m_in_A3   = s_A3;
            m_in_data = s_data;
            m_in_ctrl = s_ctrl;
        end
    end

    pipe_slot #(
        .IR_W   (IR_W),
        .A3_W   (A3_W),
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_m (
        .CLK       (CLK),
        .clear     (m_clear),
        .load      (m_load),
        .load_IR   (m_in_IR),
        .load_A3   (m_in_A3),
        .load_data (m_in_data),
        .load_ctrl (m_in_ctrl),
        .valid     (m_valid),
        .IR        (IR),
        .A3        (A3),
        .data      (data),
        .ctrl      (ctrl)
    );

    pipe_slot #(
        .IR_W   (IR_W),
        .A3_W   (A3_W),
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_s (
        .CLK       (CLK),
        .clear     (s_clear),
        .load      (s_load),
        .load_IR   (in_IR),
        .load_A3   (in_A3),
        .load_data (in_data),
        .load_ctrl (in_ctrl),
        .valid     (s_valid),
        .IR        (s_IR),
        .A3        (s_A3),
        .data      (s_data),
        .ctrl      (s_ctrl)
    );

`ifdef PIPE_STATS_EN
    logic [31:0] stall_q;

    // Saturating count of cycles where a held beat is blocked downstream; flush does not clear it
    always_ff @(posedge CLK) begin
        if (reset) begin
            stall_q <= '0;
        end else if (m_valid & ~out_ready & (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: reset, throughput, skid ordering,
// flush, bubble semantics and (when PIPE_STATS_EN is defined) stall counting.
module tb_pipe_stage_elastic;

    logic        CLK = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_IR;
    logic [4:0]  in_A3;
    logic [95:0] in_data;
    logic [2:0]  in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] IR;
    logic [4:0]  A3;
    logic [95:0] data;
    logic [2:0]  ctrl;
    logic        skid_full;
    logic [31:0] stall_cnt;

    int passed = 0;
    int total  = 0;

`ifdef PIPE_STATS_EN
    localparam logic [31:0] EXP_STALL7 = 32'd7;
`else
    localparam logic [31:0] EXP_STALL7 = 32'd0;
`endif

    pipe_stage_elastic #(
        .IR_W   (32),
        .A3_W   (5),
        .DATA_W (96),
        .CTRL_W (3)
    ) dut (
        .CLK       (CLK),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_IR     (in_IR),
        .in_A3     (in_A3),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .IR        (IR),
        .A3        (A3),
        .data      (data),
        .ctrl      (ctrl),
        .skid_full (skid_full),
        .stall_cnt (stall_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic beat(input logic v, input logic [31:0] ir, input logic [4:0] a3, input logic [2:0] c);
        in_valid = v;
        in_IR    = ir;
        in_A3    = a3;
        in_ctrl  = c;
        in_data  = {3{ir}};
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        beat(1'b1, 32'h55, 5'd7, 3'b111);
        tick(); tick();
        chk("rst_out_valid", 96'(out_valid), 96'd0);
        chk("rst_IR", 96'(IR), 96'd0);
        chk("rst_ctrl", 96'(ctrl), 96'd0);
        chk("rst_skid", 96'(skid_full), 96'd0);
        chk("rst_stall", 96'(stall_cnt), 96'd0);
        chk("rst_in_ready_low", 96'(in_ready), 96'd0);
        reset = 1'b0;
        beat(1'b0, 32'h0, 5'd0, 3'b000);
        #1;
        chk("rst_in_ready_high", 96'(in_ready), 96'd1);

        // Reset mid-stream
        out_ready = 1'b1;
        beat(1'b1, 32'h8C010004, 5'd1, 3'b011);
        tick();
        chk("ms_valid0", 96'(out_valid), 96'd1);
        chk("ms_IR0", 96'(IR), 96'h8C010004);
        beat(1'b1, 32'h00221820, 5'd3, 3'b001);
        tick();
        chk("ms_IR1", 96'(IR), 96'h00221820);
        chk("ms_A3_1", 96'(A3), 96'd3);
        reset = 1'b1;
        beat(1'b0, 32'h0, 5'd0, 3'b000);
        tick();
        reset = 1'b0;
        #1;
        chk("ms_valid_after_rst", 96'(out_valid), 96'd0);
        chk("ms_IR_after_rst", 96'(IR), 96'd0);
        chk("ms_ctrl_after_rst", 96'(ctrl), 96'd0);
        chk("ms_in_ready", 96'(in_ready), 96'd1);

        // Throughput: one beat per cycle, skid never used
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            beat(1'b1, 32'(i), 5'(i), 3'b001);
            tick();
            chk("tp_valid", 96'(out_valid), 96'd1);
            chk("tp_IR", 96'(IR), 96'(i));
            chk("tp_data", data, {3{32'(i)}});
            chk("tp_skid", 96'(skid_full), 96'd0);
            chk("tp_in_ready", 96'(in_ready), 96'd1);
        end
        beat(1'b0, 32'h0, 5'd0, 3'b000);
        tick();
        chk("tp_drain_valid", 96'(out_valid), 96'd0);
        chk("tp_drain_IR", 96'(IR), 96'd0);

        // Skid fill and in-order drain; 0xEE is offered while in_ready=0 and must not be taken
        out_ready = 1'b0;
        beat(1'b1, 32'hA, 5'd10, 3'b001);
        tick();
        chk("sk_IR_A", 96'(IR), 96'hA);
        chk("sk_skid0", 96'(skid_full), 96'd0);
        chk("sk_in_ready0", 96'(in_ready), 96'd1);
        beat(1'b1, 32'hB, 5'd11, 3'b010);
        tick();
        chk("sk_IR_A_held", 96'(IR), 96'hA);
        chk("sk_skid1", 96'(skid_full), 96'd1);
        chk("sk_in_ready1", 96'(in_ready), 96'd0);
        beat(1'b1, 32'hEE, 5'd14, 3'b100);
        tick();
        chk("sk_hold_IR", 96'(IR), 96'hA);
        chk("sk_hold_skid", 96'(skid_full), 96'd1);
        beat(1'b0, 32'h0, 5'd0, 3'b000);
        out_ready = 1'b1;
        tick();
        chk("sk_pop1_IR", 96'(IR), 96'hB);
        chk("sk_pop1_A3", 96'(A3), 96'd11);
        chk("sk_pop1_ctrl", 96'(ctrl), 96'b010);
        chk("sk_pop1_skid", 96'(skid_full), 96'd0);
        tick();
        chk("sk_pop2_valid", 96'(out_valid), 96'd0);
        chk("sk_pop2_in_ready", 96'(in_ready), 96'd1);

        // Flush with full skid drops both held entries and the incoming beat
        out_ready = 1'b0;
        beat(1'b1, 32'hA, 5'd10, 3'b001);
        tick();
        beat(1'b1, 32'hB, 5'd11, 3'b001);
        tick();
        chk("fl_pre_skid", 96'(skid_full), 96'd1);
        beat(1'b1, 32'hC, 5'd12, 3'b001);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        beat(1'b0, 32'h0, 5'd0, 3'b000);
        #1;
        chk("fl_valid", 96'(out_valid), 96'd0);
        chk("fl_ctrl", 96'(ctrl), 96'd0);
        chk("fl_IR", 96'(IR), 96'd0);
        chk("fl_skid", 96'(skid_full), 96'd0);
        chk("fl_in_ready", 96'(in_ready), 96'd1);
        out_ready = 1'b1;
        tick();
        chk("fl_no_C", 96'(out_valid), 96'd0);

        // Bubble between two beats presents zeroed control
        out_ready = 1'b1;
        beat(1'b1, 32'h11, 5'd3, 3'b001);
        tick();
        chk("bb_ctrl0", 96'(ctrl), 96'b001);
        chk("bb_A3_0", 96'(A3), 96'd3);
        beat(1'b0, 32'h0, 5'd0, 3'b000);
        tick();
        chk("bb_gap_valid", 96'(out_valid), 96'd0);
        chk("bb_gap_ctrl", 96'(ctrl), 96'd0);
        chk("bb_gap_A3", 96'(A3), 96'd0);
        beat(1'b1, 32'h12, 5'd3, 3'b001);
        tick();
        chk("bb_IR1", 96'(IR), 96'h12);
        chk("bb_ctrl1", 96'(ctrl), 96'b001);

        // Simultaneous reset and flush
        reset = 1'b1; flush = 1'b1;
        beat(1'b0, 32'h0, 5'd0, 3'b000);
        tick();
        reset = 1'b0; flush = 1'b0;
        #1;
        chk("rf_valid", 96'(out_valid), 96'd0);
        chk("rf_stall", 96'(stall_cnt), 96'd0);

        // Stall statistics: 7 stalled cycles, flush keeps count, reset clears it
        out_ready = 1'b0;
        beat(1'b1, 32'h77, 5'd7, 3'b001);
        tick();
        chk("st_start", 96'(stall_cnt), 96'd0);
        beat(1'b0, 32'h0, 5'd0, 3'b000);
        for (int i = 0; i < 7; i++) tick();
        chk("st_seven", 96'(stall_cnt), 96'(EXP_STALL7));
        out_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("st_after_flush", 96'(stall_cnt), 96'(EXP_STALL7));
        chk("st_flush_valid", 96'(out_valid), 96'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("st_after_reset", 96'(stall_cnt), 96'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
